sidi_audio_out: RTL and testbench
=================================

# sidi_audio_out

Stereo audio output stage for the SiDi SVI328 build. It sits directly downstream of the guest's mixed audio and drives the board audio pins. It takes signed 16-bit left/right samples on a valid strobe, applies a selectable gain with saturation, and holds each sample. From the held samples it produces first-order sigma-delta bitstreams for `AUDIO_L`/`AUDIO_R` and 11-bit offset-binary words for the parallel `DAC_L`/`DAC_R` outputs.

## Interface
Parameters:
- `IN_W`, 16: input sample width, signed two's complement.
- `DAC_W`, 11: parallel DAC word width; must be ≤ `IN_W`.

Ports:
- `clk_sys` in 1: system clock; all logic is on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `sample_l` in IN_W: left sample, signed.
- `sample_r` in IN_W: right sample, signed.
- `sample_valid` in 1: one-cycle strobe; both samples are taken on the same cycle.
- `gain` in 2: left shift of 0..3 (×1, ×2, ×4, ×8); sampled together with the data.
- `mute` in 1: level input; forces midscale output while high.
- `clip_clr` in 1: clears the sticky clip flag.
- `AUDIO_L` out 1: left sigma-delta bitstream.
- `AUDIO_R` out 1: right sigma-delta bitstream.
- `DAC_L` out DAC_W: left offset-binary DAC word.
- `DAC_R` out DAC_W: right offset-binary DAC word.
- `clip` out 1: sticky flag; set when any saturation occurs.

## Operation
Stage 1 (gain) is loaded on a cycle where `sample_valid` is high:
- Compute `s << gain` at IN_W+3 bits, sign-extended.
- Saturate to signed IN_W: above 0x7FFF gives 0x7FFF; below -0x8000 (0x8000) gives 0x8000.
- Register the result per channel and register a one-cycle `clip_evt`. `clip_evt` = left saturated OR right saturated.

Stage 2 (hold) loads on the cycle after a stage-1 load:
- `u = {~s[IN_W-1], s[IN_W-2:0]}` (offset binary).
- `held_l` / `held_r` take `u`, or 0x8000 if `mute` is high.
- `DAC_x = held_x[IN_W-1 -: DAC_W]`, registered.

Hold behaviour:
- Between valids, the held values and the DAC words are constant (zero-order hold).
- Asserting `mute` forces `held_x` to 0x8000 on the next clock, independent of valid.
- Deasserting `mute` leaves midscale in place until the next stage-2 load.

Sigma-delta runs every clock, independent of valid:
- `acc_x` is IN_W+1 bits.
- Update: `acc_x <= {1'b0, acc_x[IN_W-1:0]} + held_x`.
- `AUDIO_x <= acc_x_next[IN_W]`, registered.
- Long-run ones density equals `held_x` / 2^IN_W.

Clip flag:
- Set when `clip_evt` is high.
- Cleared when `clip_clr` is high.
- If set and clear happen on the same cycle, set wins.

Boundary behaviour:
- Back-to-back valids are accepted every cycle; there is no backpressure and no drop.
- `sample_valid` during `reset` is ignored.
- Reset mid-pipeline discards in-flight samples.

## Timing
Reset values:
- `held_x` = 0x8000; `acc_x` = 0.
- `AUDIO_L` = `AUDIO_R` = 0.
- `DAC_L` = `DAC_R` = 0x400.
- `clip` = 0; stage-1 registers = 0.

Latencies, with `sample_valid` on cycle N:
- `held_x` updates at edge N+2.
- `DAC_x` updates at edge N+3.
- `clip` sets at edge N+2.
- The first `AUDIO_x` bit reflecting the new value is at edge N+3.

Other timing:
- `mute` asserted on cycle M gives `held_x` = 0x8000 at edge M+1 and `DAC_x` = 0x400 at M+2.
- After reset release at midscale, `AUDIO_x` reads 0,1,0,1,… starting at the first edge. The first `acc` value is 0x08000, so bit 16 is 0; the next is 0x10000.

## Test plan
- Reset, then free-run 8 cycles with no valid: `DAC_L` = `DAC_R` = 0x400, `AUDIO_L` sequence 0,1,0,1,0,1,0,1, `clip` = 0.
- `sample_l` = 0x4000, `sample_r` = 0xC000, `gain` = 0: `DAC_L` = 0x600 and `DAC_R` = 0x200 at N+3. Over 4096 cycles `AUDIO_L` has 3072 ones and `AUDIO_R` has 1024.
- `sample_l` = 0x4000, `gain` = 2: result saturates to 0x7FFF, `DAC_L` = 0x7FF, `clip` = 1. Repeat with `sample_r` = 0xC000, `gain` = 2: `DAC_R` = 0x000 and `AUDIO_R` stays 0.
- `clip_clr` pulsed on the same cycle as a new `clip_evt`: `clip` stays 1. A pulse with no event clears it to 0 on the next edge.
- Four consecutive valids with left = 0x0000, 0x1000, 0x2000, 0x3000: `DAC_L` = 0x400, 0x480, 0x500, 0x580 on consecutive cycles from N+3, with none dropped.
- `mute` high while holding 0x7FFF: `DAC_x` = 0x400 two cycles later and the bitstream returns to alternating. Reset asserted mid-pipeline: all outputs return to their reset values on the next edge.

Source files
------------

// File: rtl/sidi_audio_out.sv
// -----------------------------------------------------------------------------
// sidi_audio_out
//
// Stereo audio output stage. It takes signed samples on a one-cycle strobe,
// applies a 0..3 bit left-shift gain with saturation, and holds the result.
// From the held values it drives first-order sigma-delta bitstreams and
// offset-binary parallel DAC words.
//
// Pipeline:  sample_valid -> stage 1 (gain/saturate) -> stage 2 (offset-binary
//            hold, mute) -> DAC register and sigma-delta accumulators.
//
// Handshake: sample_valid is a one-cycle strobe with no ready. Every strobe
//            outside reset is accepted, including back-to-back strobes.
//
// Ports:
//   clk_sys       in   system clock, rising edge
//   reset         in   synchronous, active-high reset
//   sample_l/_r   in   IN_W-bit signed samples, taken when sample_valid is high
//   sample_valid  in   one-cycle input strobe
//   gain          in   left shift 0..3, taken with the samples
//   mute          in   level; forces midscale into the hold registers
//   clip_clr      in   clears the sticky clip flag (a same-cycle set wins)
//   AUDIO_L/_R    out  sigma-delta bitstreams
//   DAC_L/_R      out  DAC_W-bit offset-binary words
//   clip          out  sticky saturation flag
// -----------------------------------------------------------------------------
module sidi_audio_out #(
    parameter int IN_W  = 16,
    parameter int DAC_W = 11
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [IN_W-1:0]  sample_l,
    input  logic [IN_W-1:0]  sample_r,
    input  logic             sample_valid,
    input  logic [1:0]       gain,
    input  logic             mute,
    input  logic             clip_clr,
    output logic             AUDIO_L,
    output logic             AUDIO_R,
    output logic [DAC_W-1:0] DAC_L,
    output logic [DAC_W-1:0] DAC_R,
    output logic             clip
);

    localparam int EXT_W = IN_W + 3;

    localparam logic [IN_W-1:0]  MIDSCALE = {1'b1, {(IN_W-1){1'b0}}};
    localparam logic [IN_W-1:0]  MAX_POS  = {1'b0, {(IN_W-1){1'b1}}};
    localparam logic [IN_W-1:0]  MAX_NEG  = {1'b1, {(IN_W-1){1'b0}}};
    localparam logic [DAC_W-1:0] DAC_MID  = {1'b1, {(DAC_W-1){1'b0}}};

    // Returns {saturated, value}. The shift is done at IN_W+3 bits so no
    // magnitude is lost; the result fits in IN_W bits only when every bit
    // from the sign bit down to bit IN_W-1 agrees.
    function automatic logic [IN_W:0] gain_sat(input logic [IN_W-1:0] s,
                                               input logic [1:0]      g);
        logic [EXT_W-1:0] ext;
        logic [EXT_W-1:0] shifted;
        logic [3:0]       top;
        ext     = {{3{s[IN_W-1]}}, s};
        shifted = ext << g;
        top     = shifted[EXT_W-1:IN_W-1];
        if (top == 4'b0000 || top == 4'b1111) begin
            gain_sat = {1'b0, shifted[IN_W-1:0]};
        end else if (shifted[EXT_W-1]) begin
            gain_sat = {1'b1, MAX_NEG};
        end else begin
            gain_sat = {1'b1, MAX_POS};
        end
    endfunction

    // Stage 1
    logic [IN_W-1:0]  s1_l_q, s1_l_d;
    logic [IN_W-1:0]  s1_r_q, s1_r_d;
    logic             s1_vld_q, s1_vld_d;
    logic             clip_evt_q, clip_evt_d;
    // Stage 2 / outputs
    logic [IN_W-1:0]  held_l_q, held_l_d;
    logic [IN_W-1:0]  held_r_q, held_r_d;
    logic [DAC_W-1:0] dac_l_q, dac_l_d;
    logic [DAC_W-1:0] dac_r_q, dac_r_d;
    // The accumulator MSB is the registered carry, so it doubles as the
    // bitstream output bit.
    logic [IN_W:0]    acc_l_q, acc_l_d;
    logic [IN_W:0]    acc_r_q, acc_r_d;
    logic             clip_q, clip_d;

    logic [IN_W:0]    sat_l;
    logic [IN_W:0]    sat_r;

    always_comb begin
        sat_l      = gain_sat(sample_l, gain);
        sat_r      = gain_sat(sample_r, gain);

        s1_l_d     = s1_l_q;
        s1_r_d     = s1_r_q;
        if (sample_valid) begin
            s1_l_d = sat_l[IN_W-1:0];
            s1_r_d = sat_r[IN_W-1:0];
        end
        s1_vld_d   = sample_valid;
        clip_evt_d = sample_valid & (sat_l[IN_W] | sat_r[IN_W]);

        // Inverting the sign bit converts two's complement to offset binary.
        held_l_d = held_l_q;
        held_r_d = held_r_q;
        if (s1_vld_q) begin
            held_l_d = {~s1_l_q[IN_W-1], s1_l_q[IN_W-2:0]};
            held_r_d = {~s1_r_q[IN_W-1], s1_r_q[IN_W-2:0]};
        end
        // Mute overrides any load and acts on its own, without a valid.
        if (mute) begin
            held_l_d = MIDSCALE;
            held_r_d = MIDSCALE;
        end

        dac_l_d = held_l_q[IN_W-1 -: DAC_W];
        dac_r_d = held_r_q[IN_W-1 -: DAC_W];

        // Drop the previous carry and add the held level: the carry out
        // density equals held / 2^IN_W.
        acc_l_d = {1'b0, acc_l_q[IN_W-1:0]} + {1'b0, held_l_q};
        acc_r_d = {1'b0, acc_r_q[IN_W-1:0]} + {1'b0, held_r_q};

        clip_d = clip_q;
        if (clip_clr) begin
            clip_d = 1'b0;
        end
        if (clip_evt_q) begin
            clip_d = 1'b1;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            s1_l_q     <= '0;
            s1_r_q     <= '0;
            s1_vld_q   <= 1'b0;
            clip_evt_q <= 1'b0;
            held_l_q   <= MIDSCALE;
            held_r_q   <= MIDSCALE;
            dac_l_q    <= DAC_MID;
            dac_r_q    <= DAC_MID;
            acc_l_q    <= '0;
            acc_r_q    <= '0;
            clip_q     <= 1'b0;
        end else begin
            s1_l_q     <= s1_l_d;
            s1_r_q     <= s1_r_d;
            s1_vld_q   <= s1_vld_d;
            clip_evt_q <= clip_evt_d;
            held_l_q   <= held_l_d;
            held_r_q   <= held_r_d;
            dac_l_q    <= dac_l_d;
            dac_r_q    <= dac_r_d;
            acc_l_q    <= acc_l_d;
            acc_r_q    <= acc_r_d;
            clip_q     <= clip_d;
        end
    end

    assign AUDIO_L = acc_l_q[IN_W];
    assign AUDIO_R = acc_r_q[IN_W];
    assign DAC_L   = dac_l_q;
    assign DAC_R   = dac_r_q;
    assign clip    = clip_q;

endmodule

// File: tb/tb_sidi_audio_out.sv
// -----------------------------------------------------------------------------
// tb_sidi_audio_out
//
// Each accepted sample pushes its expected DAC words, tagged with the cycle
// they must appear, onto exp_q; a negedge monitor pops and compares them.
// Directed checks cover reset, bitstream density, saturation, the sticky
// clip flag, mute and reset mid-pipeline.
// -----------------------------------------------------------------------------
module tb_sidi_audio_out;

    localparam int IN_W  = 16;
    localparam int DAC_W = 11;
    localparam int EXP_W = 32 + 2 * DAC_W;

    // ---------------- clock / reset ----------------
    logic             clk_sys = 1'b0;
    logic             reset;
    logic [IN_W-1:0]  sample_l;
    logic [IN_W-1:0]  sample_r;
    logic             sample_valid;
    logic [1:0]       gain;
    logic             mute;
    logic             clip_clr;
    logic             AUDIO_L;
    logic             AUDIO_R;
    logic [DAC_W-1:0] DAC_L;
    logic [DAC_W-1:0] DAC_R;
    logic             clip;

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    sidi_audio_out #(.IN_W(IN_W), .DAC_W(DAC_W)) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid),
        .gain         (gain),
        .mute         (mute),
        .clip_clr     (clip_clr),
        .AUDIO_L      (AUDIO_L),
        .AUDIO_R      (AUDIO_R),
        .DAC_L        (DAC_L),
        .DAC_R        (DAC_R),
        .clip         (clip)
    );

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: gain as a multiply, clamp, then offset and truncate.
    function automatic logic [DAC_W-1:0] dac_model(input logic [IN_W-1:0] s, input int g);
        int v;
        int u;
        v = int'($signed(s)) * (1 << g);
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        u = v + 32768;
        return DAC_W'(u >> (IN_W - DAC_W));
    endfunction

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    logic [EXP_W-1:0] mon_e;

    always @(negedge clk_sys) begin
        while (exp_q.size() > 0 && exp_q[0][EXP_W-1 -: 32] <= cyc) begin
            mon_e = exp_q.pop_front();
            chk("dac_l", 32'(DAC_L), 32'(mon_e[2*DAC_W-1 -: DAC_W]));
            chk("dac_r", 32'(DAC_R), 32'(mon_e[DAC_W-1:0]));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk_sys);
        #1;
    endtask

    // Drives one strobe (left high for the caller to clear) and records the
    // DAC words due three edges later.
    task automatic drive_sample(input logic [IN_W-1:0] l, input logic [IN_W-1:0] r, input int g);
        logic [DAC_W-1:0] el;
        logic [DAC_W-1:0] er;
        sample_l     = l;
        sample_r     = r;
        gain         = 2'(g);
        sample_valid = 1'b1;
        el = mute ? DAC_W'(11'h400) : dac_model(l, g);
        er = mute ? DAC_W'(11'h400) : dac_model(r, g);
        exp_q.push_back({32'(cyc + 3), el, er});
        step();
    endtask

    task automatic send(input logic [IN_W-1:0] l, input logic [IN_W-1:0] r, input int g);
        drive_sample(l, r, g);
        sample_valid = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    int ones_l;
    int ones_r;

    initial begin
        reset = 1'b1; sample_l = '0; sample_r = '0; sample_valid = 1'b0;
        gain = 2'd0; mute = 1'b0; clip_clr = 1'b0;
        step(); step();
        chk("rst_dac_l", 32'(DAC_L), 32'h400);
        chk("rst_dac_r", 32'(DAC_R), 32'h400);
        chk("rst_audio_l", 32'(AUDIO_L), 0);
        chk("rst_audio_r", 32'(AUDIO_R), 0);
        chk("rst_clip", 32'(clip), 0);

        // Idle at midscale: alternating bitstream starting with 0.
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("idle_audio_l", 32'(AUDIO_L), 32'(i % 2));
            chk("idle_audio_r", 32'(AUDIO_R), 32'(i % 2));
        end
        chk("idle_dac_l", 32'(DAC_L), 32'h400);
        chk("idle_clip", 32'(clip), 0);

        // Quarter-scale levels and their ones density.
        send(16'h4000, 16'hC000, 0);
        step();
        chk("dac_l_not_yet", 32'(DAC_L), 32'h400);
        ones_l = 0; ones_r = 0;
        for (int i = 0; i < 4096; i++) begin
            step();
            ones_l += int'(AUDIO_L);
            ones_r += int'(AUDIO_R);
        end
        chk("density_l", 32'(ones_l), 3072);
        chk("density_r", 32'(ones_r), 1024);
        chk("no_clip", 32'(clip), 0);

        // Saturation positive then negative.
        send(16'h4000, 16'h0000, 2);
        step();
        chk("clip_set", 32'(clip), 1);
        step(); step();
        send(16'h0000, 16'hC000, 2);
        step(); step();
        ones_r = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            ones_r += int'(AUDIO_R);
        end
        chk("audio_r_floor", 32'(ones_r), 0);

        // Sticky flag: clear alone, then clear colliding with a new event.
        clip_clr = 1'b1; step(); clip_clr = 1'b0;
        chk("clip_cleared", 32'(clip), 0);
        step();
        chk("clip_stays_clr", 32'(clip), 0);
        send(16'h7000, 16'h0000, 1);
        clip_clr = 1'b1; step(); clip_clr = 1'b0;
        chk("clip_set_wins", 32'(clip), 1);
        step(); step();
        clip_clr = 1'b1; step(); clip_clr = 1'b0;
        chk("clip_clr_again", 32'(clip), 0);

        // Back-to-back strobes, none dropped.
        for (int i = 0; i < 4; i++) begin
            drive_sample(16'(i * 16'h1000), 16'(-(i * 16'h0800)), 0);
        end
        sample_valid = 1'b0;
        repeat (5) step();
        chk("hold_dac_l", 32'(DAC_L), 32'h580);
        chk("b2b_no_clip", 32'(clip), 0);
        chk("b2b_drained", 32'(exp_q.size()), 0);

        // Random samples and gains with random gaps.
        for (int k = 0; k < 12; k++) begin
            send(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                 int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) step();
        end
        repeat (4) step();

        // Mute while holding full scale.
        send(16'h7FFF, 16'h7FFF, 0);
        repeat (4) step();
        mute = 1'b1;
        step();
        chk("mute_dac_n1", 32'(DAC_L), 32'h7FF);
        step();
        chk("mute_dac_l", 32'(DAC_L), 32'h400);
        chk("mute_dac_r", 32'(DAC_R), 32'h400);
        ones_l = 0; ones_r = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            ones_l += int'(AUDIO_L);
            ones_r += int'(AUDIO_R);
        end
        chk("mute_density_l", 32'(ones_l), 8);
        chk("mute_density_r", 32'(ones_r), 8);
        send(16'h4000, 16'h4000, 0);
        repeat (4) step();
        mute = 1'b0;
        repeat (4) step();
        chk("unmute_hold", 32'(DAC_L), 32'h400);
        send(16'h4000, 16'hC000, 0);
        repeat (4) step();

        // Reset with a saturating sample in flight.
        send(16'h2000, 16'h2000, 3);
        reset = 1'b1;
        exp_q.delete();
        step();
        chk("midrst_dac_l", 32'(DAC_L), 32'h400);
        chk("midrst_dac_r", 32'(DAC_R), 32'h400);
        chk("midrst_audio_l", 32'(AUDIO_L), 0);
        chk("midrst_audio_r", 32'(AUDIO_R), 0);
        chk("midrst_clip", 32'(clip), 0);
        // Strobe during reset must be ignored.
        sample_l = 16'h4000; sample_r = 16'h4000; gain = 2'd3; sample_valid = 1'b1;
        step();
        reset = 1'b0; sample_valid = 1'b0;
        repeat (4) step();
        chk("post_rst_dac_l", 32'(DAC_L), 32'h400);
        chk("post_rst_clip", 32'(clip), 0);

        repeat (4) step();
        chk("queue_empty", 32'(exp_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
